sumador_normalizador: RTL and testbench



---
 rtl/sumador_normalizador_pkg.sv | 20 ++
 rtl/sumador_normalizador_lzc.sv | 18 +
 rtl/sumador_normalizador.sv | 170 +++++++++++++++++
 tb/tb_sumador_normalizador.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sumador_normalizador_pkg.sv
// Shared definitions for the FP adder's add/normalize/round stage:
// FSM encoding, datapath widths and exception bit positions.
package sumador_normalizador_pkg;

  localparam int MANT_W   = 26;
  localparam int EXP_MAX  = 255;
  localparam int EXP_BIAS = 127;

  localparam int EXC_OVF = 0;
  localparam int EXC_UNF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUMA,
    ST_NORM,
    ST_REDONDEO,
    ST_SALIDA
  } state_t;

endpackage

// File: rtl/sumador_normalizador_lzc.sv
// lzc_26: combinational leading-zero counter over a 26-bit mantissa.
// Returns 26 for an all-zero input.
module lzc_26
  import sumador_normalizador_pkg::*;
(
  input  logic [MANT_W-1:0] i_data,
  output logic [4:0]        o_count
);

  always_comb begin
    o_count = 5'd26;
    // Scanning upward lets the most significant set bit win.
    for (int i = 0; i < MANT_W; i++) begin
      if (i_data[i]) o_count = 5'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/sumador_normalizador.sv
// Add/subtract, normalize and round stage of the single-precision FP adder.
// Build option LZC_NORM_EN: single-cycle normalization via lzc_26 instead of one shift per cycle.
module sumador_normalizador
  import sumador_normalizador_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              Signo_A,
  input  logic              Signo_B,
  input  logic [MANT_W-1:0] Mantissa_A,
  input  logic [MANT_W-1:0] Mantissa_B,
  input  logic [7:0]        Exp_comun,
  output logic [31:0]       Resultado,
  output logic [1:0]        Excepcion,
  output logic              valid_out,
  input  logic              ready_out
);

  state_t r_state, w_state_next;

  logic              r_sign_a, r_sign_b;
  logic [MANT_W-1:0] r_mant_a, r_mant_b;
  logic [MANT_W:0]   r_mant;
  logic [8:0]        r_exp;
  logic              r_sign;
  logic              r_unf;
  logic [31:0]       r_result;
  logic [1:0]        r_exc;

  logic            w_sum_sign;
  logic [MANT_W:0] w_sum;

  always_comb begin
    w_sum      = '0;
    w_sum_sign = r_sign_a;
    if (r_sign_a == r_sign_b) begin
      w_sum = {1'b0, r_mant_a} + {1'b0, r_mant_b};
    end else if (r_mant_a >= r_mant_b) begin
      w_sum = {1'b0, r_mant_a} - {1'b0, r_mant_b};
    end else begin
      w_sum      = {1'b0, r_mant_b} - {1'b0, r_mant_a};
      w_sum_sign = r_sign_b;
    end
  end

  logic w_carry, w_hidden, w_zero, w_exp_low, w_unf, w_norm_done;

  assign w_carry   = r_mant[MANT_W];
  assign w_hidden  = r_mant[MANT_W-1];
  assign w_zero    = (r_mant == '0);
  assign w_exp_low = (r_exp <= 9'd1);

`ifdef LZC_NORM_EN
  logic [4:0] w_lz;
  logic [8:0] w_max_sh;

  lzc_26 u_lzc (
    .i_data  (r_mant[MANT_W-1:0]),
    .o_count (w_lz)
  );

  // The shift may not take the exponent below 1; needing more is an underflow.
  assign w_max_sh    = w_exp_low ? 9'd0 : (r_exp - 9'd1);
  assign w_unf       = !w_carry && !w_hidden && ({4'd0, w_lz} > w_max_sh);
  assign w_norm_done = 1'b1;
`else
  assign w_unf       = !w_carry && !w_hidden && w_exp_low;
  assign w_norm_done = w_carry || w_hidden || w_unf;
`endif

  // Round to nearest-even on {guard, round}; a carry out renormalizes in place.
  logic        w_inc, w_ovf;
  logic [24:0] w_rnd;
  logic [8:0]  w_rexp;
  logic [22:0] w_frac;

  assign w_inc  = r_mant[1] & (r_mant[0] | r_mant[2]);
  assign w_rnd  = {1'b0, r_mant[MANT_W-1:2]} + {24'd0, w_inc};
  assign w_rexp = r_exp + {8'd0, w_rnd[24]};
  assign w_frac = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
  assign w_ovf  = (w_rexp >= 9'(EXP_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (valid_in) w_state_next = ST_SUMA;
      ST_SUMA:     w_state_next = ST_NORM;
      // An exact-zero sum is caught on the first NORM cycle and skips rounding.
      ST_NORM: begin
        if (w_zero)           w_state_next = ST_SALIDA;
        else if (w_norm_done) w_state_next = ST_REDONDEO;
      end
      ST_REDONDEO: w_state_next = ST_SALIDA;
      ST_SALIDA:   if (ready_out) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mant_a <= '0;
      r_mant_b <= '0;
      r_mant   <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_unf    <= 1'b0;
      r_result <= '0;
      r_exc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_sign_a <= Signo_A;
            r_sign_b <= Signo_B;
            r_mant_a <= Mantissa_A;
            r_mant_b <= Mantissa_B;
            r_exp    <= {1'b0, Exp_comun};
          end
        end
        ST_SUMA: begin
          r_mant <= w_sum;
          r_sign <= w_sum_sign;
          r_unf  <= 1'b0;
        end
        ST_NORM: begin
          if (w_zero) begin
            r_result <= '0;
            r_exc    <= '0;
          end else if (w_carry) begin
            r_mant <= r_mant >> 1;
            r_exp  <= r_exp + 9'd1;
          end else if (w_unf) begin
            r_mant <= '0;
            r_exp  <= '0;
            r_unf  <= 1'b1;
          end else if (!w_hidden) begin
`ifdef LZC_NORM_EN
            r_mant <= r_mant << w_lz;
            r_exp  <= r_exp - {4'd0, w_lz};
`else
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - 9'd1;
`endif
          end
        end
        ST_REDONDEO: begin
          r_result         <= w_ovf ? {r_sign, 8'hFF, 23'd0} : {r_sign, w_rexp[7:0], w_frac};
          r_exc[EXC_OVF]   <= w_ovf;
          r_exc[EXC_UNF]   <= r_unf;
        end
        default: ;
      endcase
    end
  end

  assign ready_in  = (r_state == ST_IDLE);
  assign valid_out = (r_state == ST_SALIDA);
  assign Resultado = r_result;
  assign Excepcion = r_exc;

endmodule

// File: tb/tb_sumador_normalizador.sv
// Self-checking bench for sumador_normalizador: directed cases plus randomized
// operands checked against an arithmetic reference model.
module tb_sumador_normalizador;
  import sumador_normalizador_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic        Signo_A;
  logic        Signo_B;
  logic [25:0] Mantissa_A;
  logic [25:0] Mantissa_B;
  logic [7:0]  Exp_comun;
  logic [31:0] Resultado;
  logic [1:0]  Excepcion;
  logic        valid_out;
  logic        ready_out;

  int n_vec = 0;
  int n_err = 0;

  sumador_normalizador dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .Signo_A    (Signo_A),
    .Signo_B    (Signo_B),
    .Mantissa_A (Mantissa_A),
    .Mantissa_B (Mantissa_B),
    .Exp_comun  (Exp_comun),
    .Resultado  (Resultado),
    .Excepcion  (Excepcion),
    .valid_out  (valid_out),
    .ready_out  (ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: exact integer add/sub, normalize by scaling, round-half-even on the two low bits.
  function automatic void model(input bit sa, input bit sb, input longint ma, input longint mb,
                                input int e, output logic [31:0] res, output logic [1:0] exc,
                                output int lat);
    longint m, sig, rb;
    int     ex, shifts;
    bit     s;
    exc = 2'b00;
    if (sa == sb)      begin m = ma + mb; s = sa; end
    else if (ma >= mb) begin m = ma - mb; s = sa; end
    else               begin m = mb - ma; s = sb; end
    if (m == 0) begin
      res = 32'd0;
      lat = 2;
      return;
    end
    ex = e;
    shifts = 0;
    if (m >= 64'd67108864) begin
      m = m / 2;
      ex = ex + 1;
    end else begin
      while (m < 64'd33554432) begin
        if (ex <= 1) begin
          m = 0;
          ex = 0;
          exc[1] = 1'b1;
          break;
        end
        m = m * 2;
        ex = ex - 1;
        shifts++;
      end
    end
    sig = m / 4;
    rb  = m % 4;
    if (rb == 3 || (rb == 2 && (sig % 2) == 1)) sig = sig + 1;
    if (sig >= 64'd16777216) begin
      sig = sig / 2;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      res = {s, 8'hFF, 23'd0};
      exc[0] = 1'b1;
    end else begin
      res = {s, 8'(ex), 23'(sig)};
    end
`ifdef LZC_NORM_EN
    lat = 3;
`else
    lat = 3 + shifts;
`endif
  endfunction

  task automatic do_op(input string tag, input bit sa, input bit sb, input logic [25:0] ma,
                       input logic [25:0] mb, input logic [7:0] e, input bit hold);
    logic [31:0] er;
    logic [1:0]  ee;
    int          el, cyc;
    model(sa, sb, longint'(ma), longint'(mb), int'(e), er, ee, el);
    @(negedge clk);
    check({tag, ".ready_in_idle"}, 32'(ready_in), 32'd1);
    Signo_A = sa; Signo_B = sb; Mantissa_A = ma; Mantissa_B = mb; Exp_comun = e;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    // Junk operands with valid_in high while busy must be ignored.
    Signo_A = ~sa;
    Mantissa_A = 26'($urandom);
    Mantissa_B = 26'($urandom);
    Exp_comun  = 8'($urandom);
    cyc = 0;
    while (cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid_out) break;
    end
    valid_in = 1'b0;
    $display("op %s: A=%h B=%h sA=%0d sB=%0d E=%0d -> %h exc=%b lat=%0d", tag, ma, mb, sa, sb, e,
             Resultado, Excepcion, cyc);
    check({tag, ".latency"}, 32'(cyc), 32'(el));
    check({tag, ".resultado"}, Resultado, er);
    check({tag, ".excepcion"}, 32'(Excepcion), 32'(ee));
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        check({tag, ".hold_res"}, Resultado, er);
        check({tag, ".hold_valid"}, 32'(valid_out), 32'd1);
        check({tag, ".hold_ready_in"}, 32'(ready_in), 32'd0);
      end
    end
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    ready_out = 1'b0;
    check({tag, ".ready_in_after"}, 32'(ready_in), 32'd1);
    check({tag, ".valid_out_after"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
    Signo_A = 1'b0; Signo_B = 1'b0; Mantissa_A = '0; Mantissa_B = '0; Exp_comun = '0;

    #2;
    check("reset.ready_in", 32'(ready_in), 32'd1);
    check("reset.valid_out", 32'(valid_out), 32'd0);
    check("reset.resultado", Resultado, 32'd0);
    check("reset.excepcion", 32'(Excepcion), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("one_plus_one", 1'b0, 1'b0, 26'h2000000, 26'h2000000, 8'(EXP_BIAS), 1'b1);
    check("one_plus_one.value", Resultado, 32'h40000000);
    do_op("one_minus_one", 1'b0, 1'b1, 26'h2000000, 26'h2000000, 8'(EXP_BIAS), 1'b0);
    check("one_minus_one.value", Resultado, 32'h00000000);
    do_op("1p5_minus_1p25", 1'b0, 1'b1, 26'h3000000, 26'h2800000, 8'(EXP_BIAS), 1'b0);
    check("1p5_minus_1p25.value", Resultado, 32'h3E800000);
    do_op("round_tie_carry", 1'b0, 1'b0, 26'h3FFFFFE, 26'h0000000, 8'(EXP_BIAS), 1'b0);
    check("round_tie_carry.value", Resultado, 32'h40000000);
    do_op("overflow", 1'b0, 1'b0, 26'h2000000, 26'h2000000, 8'd254, 1'b0);
    check("overflow.value", Resultado, 32'h7F800000);
    check("overflow.exc", 32'(Excepcion), 32'd1);
    do_op("underflow", 1'b1, 1'b0, 26'h2000000, 26'h1FFFFFF, 8'd5, 1'b0);
    check("underflow.value", Resultado, 32'h80000000);
    check("underflow.exc", 32'(Excepcion), 32'd2);
    do_op("tie_even_down", 1'b0, 1'b0, 26'h2000002, 26'h0000000, 8'd100, 1'b0);
    check("tie_even_down.value", Resultado, 32'h32000000);

    // Reset in the middle of normalization, with a nonzero result still held.
    do_op("pre_reset", 1'b1, 1'b1, 26'h2400000, 26'h2000000, 8'd130, 1'b0);
    @(negedge clk);
    Signo_A = 1'b0; Signo_B = 1'b1; Mantissa_A = 26'h3000000; Mantissa_B = 26'h2800000;
    Exp_comun = 8'(EXP_BIAS); valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset.ready_in", 32'(ready_in), 32'd1);
    check("midreset.valid_out", 32'(valid_out), 32'd0);
    check("midreset.resultado", Resultado, 32'd0);
    check("midreset.excepcion", 32'(Excepcion), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midreset.discarded", 32'(valid_out), 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [25:0] a, b;
      logic        sa, sb;
      logic [7:0]  e;
      a = 26'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 26'($urandom);
        1:       b = a ^ 26'($urandom_range(0, 255));
        2:       b = a >> $urandom_range(0, 25);
        default: begin
          a[25] = 1'b1;
          b = 26'($urandom) >> $urandom_range(1, 25);
        end
      endcase
      sa = 1'($urandom);
      sb = 1'($urandom);
      e  = 8'($urandom_range(1, 254));
      do_op("rnd", sa, sb, a, b, e, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
